window_spill_fill_ctrl: RTL

//  Hardware window overflow/underflow engine for the 4-window SPARC register file.

---
 rtl/win_sf_pkg.sv | 20 ++
 rtl/window_spill_fill_ctrl_if.sv | 35 +++
 rtl/win_sf_addr_gen.sv | 34 +++
 rtl/window_spill_fill_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/win_sf_pkg.sv
// Shared constants and FSM state encoding for the register-window spill/fill engine.
package win_sf_pkg;
  localparam int unsigned NREGS      = 16;
  localparam int unsigned BASE_REG   = 16;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WIN_W      = 2;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned CNT_W      = $clog2(NREGS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SP_RD,
    ST_SP_MEM,
    ST_FL_MEM,
    ST_FL_WR,
    ST_DONE
  } state_t;
endpackage

// File: rtl/window_spill_fill_ctrl_if.sv
// Control, register-file and memory-port signals of the spill/fill engine.
interface window_spill_fill_ctrl_if;
  import win_sf_pkg::*;

  logic              spill_req;
  logic              fill_req;
  logic [WIN_W-1:0]  win;
  logic [ADDR_W-1:0] sp;
  logic              busy;
  logic              done;
  logic [WIN_W-1:0]  rf_cwp;
  logic [REG_W-1:0]  rf_ra;
  logic [DATA_W-1:0] rf_aout;
  logic [REG_W-1:0]  rf_rc;
  logic [DATA_W-1:0] rf_rin;
  logic              rf_rfe;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  spill_req, fill_req, win, sp, rf_aout, mem_ack, mem_rdata,
    output busy, done, rf_cwp, rf_ra, rf_rc, rf_rin, rf_rfe,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output spill_req, fill_req, win, sp, rf_aout, mem_ack, mem_rdata,
    input  busy, done, rf_cwp, rf_ra, rf_rc, rf_rin, rf_rfe,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/win_sf_addr_gen.sv
// Word counter with registered memory address and register index for one transfer.
module win_sf_addr_gen
  import win_sf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inc,
  input  logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] addr,
  output logic [REG_W-1:0]  reg_idx,
  output logic              last_c
);
  logic [CNT_W-1:0] cnt;

  // Address advances by one word alongside the counter; wraps modulo 2^ADDR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      addr    <= '0;
      reg_idx <= '0;
    end else if (start) begin
      cnt     <= '0;
      addr    <= sp & ~ADDR_W'(WORD_BYTES - 1);
      reg_idx <= REG_W'(BASE_REG);
    end else if (inc) begin
      cnt     <= cnt + CNT_W'(1);
      addr    <= addr + ADDR_W'(WORD_BYTES);
      reg_idx <= reg_idx + REG_W'(1);
    end
  end

  assign last_c = (cnt == CNT_W'(NREGS - 1));
endmodule

// File: rtl/window_spill_fill_ctrl.sv
// Window overflow/underflow engine: moves r16..r31 of one window to or from memory.
module window_spill_fill_ctrl
  import win_sf_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  window_spill_fill_ctrl_if.master       bus
);
  state_t            state, state_d;
  logic              start_c, inc_c, last_c;
  logic [ADDR_W-1:0] addr;
  logic [REG_W-1:0]  reg_idx;

  win_sf_addr_gen u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .start   (start_c),
    .inc     (inc_c),
    .sp      (bus.sp),
    .addr    (addr),
    .reg_idx (reg_idx),
    .last_c  (last_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Spill has priority over fill; requests are only looked at in IDLE.
  always_comb begin
    state_d = state;
    start_c = 1'b0;
    inc_c   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.spill_req) begin
          state_d = ST_SP_RD;
          start_c = 1'b1;
        end else if (bus.fill_req) begin
          state_d = ST_FL_MEM;
          start_c = 1'b1;
        end
      end
      ST_SP_RD:  state_d = ST_SP_MEM;
      ST_SP_MEM: begin
        if (bus.mem_ack) begin
          if (last_c) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SP_RD;
            inc_c   = 1'b1;
          end
        end
      end
      ST_FL_MEM: if (bus.mem_ack) state_d = ST_FL_WR;
      ST_FL_WR: begin
        if (last_c) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FL_MEM;
          inc_c   = 1'b1;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.rf_rfe    <= 1'b0;
      bus.rf_cwp    <= '0;
      bus.mem_wdata <= '0;
      bus.rf_rin    <= '0;
    end else begin
      bus.busy    <= (state_d != ST_IDLE);
      bus.done    <= (state_d == ST_DONE);
      bus.mem_req <= (state_d == ST_SP_MEM) || (state_d == ST_FL_MEM);
      bus.mem_we  <= (state_d == ST_SP_MEM);
      bus.rf_rfe  <= (state_d == ST_FL_WR);
      if (start_c)                               bus.rf_cwp    <= bus.win;
      if (state == ST_SP_RD)                     bus.mem_wdata <= bus.rf_aout;
      if ((state == ST_FL_MEM) && bus.mem_ack)   bus.rf_rin    <= bus.mem_rdata;
    end
  end

  assign bus.rf_ra    = reg_idx;
  assign bus.rf_rc    = reg_idx;
  assign bus.mem_addr = addr;
endmodule
